// File: rtl/csa_mul_share_ctrl_pkg.sv
// rtl/csa_mul_share_ctrl_pkg.sv - shared constants and FSM encoding for the shared-multiplier controller
package csa_mul_share_ctrl_pkg;

    localparam int OPW = 4;
    localparam int PW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/csa_mul4.sv
// rtl/csa_mul4.sv - combinational 4x4 unsigned carry-save array multiplier
module csa_mul4
    import csa_mul_share_ctrl_pkg::*;
(
    input  logic [OPW-1:0] a_i,
    input  logic [OPW-1:0] b_i,
    output logic [PW-1:0]  p_o
);

    logic [PW-1:0] sum;
    logic [PW-1:0] cry;
    logic [PW-1:0] row;
    logic [PW-1:0] nsum;
    logic [PW-1:0] ncry;

    // Each partial-product row is folded in with a 3:2 compressor; the carry out of
    // bit 7 is always zero because the true running total never reaches 256.
    always_comb begin
        sum  = PW'(a_i & {OPW{b_i[0]}});
        cry  = '0;
        row  = '0;
        nsum = '0;
        ncry = '0;
        for (int i = 1; i < OPW; i++) begin
            row  = PW'(a_i & {OPW{b_i[i]}}) << i;
            nsum = sum ^ cry ^ row;
            ncry = ((sum & cry) | (sum & row) | (cry & row)) << 1;
            sum  = nsum;
            cry  = ncry;
        end
        p_o = sum + cry;
    end

endmodule

// File: rtl/csa_mul_share_ctrl_arb.sv
// rtl/csa_mul_share_ctrl_arb.sv - combinational round-robin arbiter starting its search at ptr_i
module rr_arbiter_n #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            enable_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            grant_valid_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_i) + k) % NREQ;
            if (enable_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDW'(idx);
            end
        end
    end

    assign grant_valid_o = found;

endmodule

// File: rtl/csa_mul_share_ctrl.sv
// rtl/csa_mul_share_ctrl.sv - round-robin sharing of one carry-save multiplier among NREQ requesters
module csa_mul_share_ctrl
    import csa_mul_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [OPW*NREQ-1:0]  req_a,
    input  logic [OPW*NREQ-1:0]  req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [PW-1:0]        resp_p,
    output logic                 busy,
    output logic [CNTW-1:0]      done_count
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OPW-1:0]  op_a_q, op_a_d;
    logic [OPW-1:0]  op_b_q, op_b_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [PW-1:0]   resp_p_q, resp_p_d;
    logic            resp_valid_q, resp_valid_d;
    logic [CNTW-1:0] done_count_q, done_count_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;
    logic [PW-1:0]   mul_p;

    rr_arbiter_n #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i         (req_valid),
        .ptr_i         (rr_ptr_q),
        .enable_i      (state_q == ST_IDLE),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    csa_mul4 u_mul (
        .a_i (op_a_q),
        .b_i (op_b_q),
        .p_o (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            id_q         <= '0;
            resp_p_q     <= '0;
            resp_valid_q <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            id_q         <= id_d;
            resp_p_q     <= resp_p_d;
            resp_valid_q <= resp_valid_d;
            done_count_q <= done_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        id_d         = id_q;
        resp_p_d     = resp_p_q;
        resp_valid_d = resp_valid_q;
        done_count_d = done_count_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    op_a_d   = req_a[int'(grant_idx)*OPW +: OPW];
                    op_b_d   = req_b[int'(grant_idx)*OPW +: OPW];
                    id_d     = grant_idx;
                    rr_ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                resp_p_d     = mul_p;
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // resp_p/resp_id stay registered until the consumer takes them
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    done_count_d = done_count_q + 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready  = grant;
    assign resp_valid = resp_valid_q;
    assign resp_id    = id_q;
    assign resp_p     = resp_p_q;
    assign busy       = (state_q != ST_IDLE);
    assign done_count = done_count_q;

endmodule

// File: tb/tb_csa_mul_share_ctrl.sv
// tb/tb_csa_mul_share_ctrl.sv - scoreboard bench for the shared-multiplier controller
module tb_csa_mul_share_ctrl;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        resp_p;
    logic              busy;
    logic [CNTW-1:0]   done_count;

    csa_mul_share_ctrl #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .busy       (busy),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int p;
    } exp_t;

    int              total = 0;
    int              bad   = 0;
    exp_t            sbq[$];
    int              grant_log[$];
    int              m_ptr   = 0;
    bit              m_idle  = 1'b1;
    int              m_since = 0;
    logic [CNTW-1:0] m_done  = '0;
    int              hs_total = 0;
    logic [NREQ-1:0] acc_mask = '0;
    int              last_p  = -1;
    int              last_id = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: who should win, what product is owed, when it is due
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            grant_log.delete();
            m_ptr    = 0;
            m_idle   = 1'b1;
            m_since  = 0;
            m_done   = '0;
            hs_total = 0;
            acc_mask = '0;
        end else begin
            chk("busy", busy, !m_idle);
            chk("done_count", done_count, m_done);
            if (m_idle) begin
                int g;
                g = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int j;
                    j = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
                chk("req_ready_idle", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
                chk("resp_valid_idle", resp_valid, 0);
                acc_mask = req_ready & req_valid;
                if (g >= 0) begin
                    exp_t e;
                    e.id = g;
                    e.p  = int'(req_a[g*4 +: 4]) * int'(req_b[g*4 +: 4]);
                    sbq.push_back(e);
                    grant_log.push_back(g);
                    m_ptr   = (g + 1) % NREQ;
                    m_idle  = 1'b0;
                    m_since = 0;
                end
            end else begin
                acc_mask = '0;
                m_since++;
                chk("req_ready_busy", req_ready, 0);
                chk("resp_valid", resp_valid, m_since >= 2);
                if (m_since >= 2 && sbq.size() > 0) begin
                    chk("resp_id", resp_id, sbq[0].id);
                    chk("resp_p", resp_p, sbq[0].p);
                    if (resp_ready) begin
                        last_p  = int'(resp_p);
                        last_id = int'(resp_id);
                        void'(sbq.pop_front());
                        m_idle = 1'b1;
                        m_done = m_done + 1'b1;
                        hs_total++;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_p"}, resp_p, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done_count"}, done_count, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
    endtask

    task automatic issue(input int i, input int a, input int b);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_a[i*4 +: 4] = 4'(a);
        req_b[i*4 +: 4] = 4'(b);
        req_valid[i]    = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (acc_mask[i]) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid[i] = 1'b0;
        chk("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (!busy && sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("idle_timeout", ok, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        #1;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int seen;
        int exp_order[5];
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        #1 rst_n = 1'b1;

        issue(0, 3, 5);
        wait_idle();
        chk("single_p", last_p, 15);
        chk("single_id", last_id, 0);
        chk("single_done", done_count, 1);

        issue(2, 15, 15); wait_idle(); chk("p_15x15", last_p, 225);
        issue(2, 0, 9);   wait_idle(); chk("p_0x9", last_p, 0);
        issue(2, 8, 2);   wait_idle(); chk("p_8x2", last_p, 16);

        // Backpressure with a competing requester waiting
        resp_ready = 1'b0;
        issue(1, 7, 6);
        req_a[12 +: 4] = 4'd2;
        req_b[12 +: 4] = 4'd3;
        req_valid[3]   = 1'b1;
        seen = 0;
        for (int c = 0; c < 10 && !resp_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("bp_resp_valid", resp_valid, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_p", resp_p, 42);
            chk("bp_id", resp_id, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_busy_after", busy, 0);
        chk("bp_last_p", last_p, 42);
        for (int c = 0; c < 20 && !acc_mask[3]; c++) begin
            @(posedge clk); #1;
        end
        req_valid[3] = 1'b0;
        wait_idle();

        // All requesters continuously valid from a fresh pointer
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*4 +: 4] = 4'(i + 1);
            req_b[i*4 +: 4] = 4'(i + 9);
        end
        req_valid = '1;
        seen = 0;
        for (int c = 0; c < 100 && grant_log.size() < 5; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++)
                if (acc_mask[i]) begin
                    seen++;
                    req_a[i*4 +: 4] = 4'((i + seen) % 16);
                    req_b[i*4 +: 4] = 4'((3 * seen + i) % 16);
                end
        end
        req_valid = '0;
        exp_order = '{0, 1, 2, 3, 0};
        chk("arb_grants", grant_log.size() >= 5, 1);
        for (int k = 0; k < 5 && k < grant_log.size(); k++)
            chk($sformatf("arb_order%0d", k), grant_log[k], exp_order[k]);
        wait_idle();

        // Reset while the multiplier cycle is in flight
        issue(1, 9, 9);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midop");
        req_a[0 +: 4] = 4'd4;  req_b[0 +: 4] = 4'd4;
        req_a[8 +: 4] = 4'd5;  req_b[8 +: 4] = 4'd5;
        req_valid = 4'b0101;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 40 && grant_log.size() < 2; c++) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~acc_mask;
        end
        req_valid = '0;
        chk("midop_grants", grant_log.size() >= 2, 1);
        if (grant_log.size() >= 2) begin
            chk("midop_first", grant_log[0], 0);
            chk("midop_second", grant_log[1], 2);
        end
        wait_idle();
        chk("midop_done", done_count, 2);

        // Random traffic until 256 handshakes since the last reset
        for (int c = 0; c < 20000 && hs_total < 256; c++) begin
            @(posedge clk); #1;
            if (hs_total >= 256) break;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_mask[i]) req_valid[i] = 1'b0;
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_a[i*4 +: 4] = 4'($urandom_range(0, 15));
                    req_b[i*4 +: 4] = 4'($urandom_range(0, 15));
                    req_valid[i]    = 1'b1;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        chk("wrap_hs", hs_total, 256);
        chk("wrap_done", done_count, 0);
        resp_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/csa_mul_share_ctrl.md
Name: csa_mul_share_ctrl

Overview:
Sequencing and arbitration controller that shares one instance of the team's combinational 4-bit carry-save array multiplier among NREQ requesters. The controller grants requesters round-robin, registers the granted operands into the multiplier and registers the 8-bit product. It then returns the product with a requester ID over a valid/ready response channel. It sits between client blocks and the multiplier datapath, which stays purely combinational.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of resp_id; must equal clog2(NREQ), minimum 1
CNTW, 8, width of the completed-operation counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_a  input  4*NREQ  flat operand A; requester i uses bits [4i+3:4i]
req_b  input  4*NREQ  flat operand B, same packing
resp_valid  output  1  product available
resp_ready  input  1  response consumer accept
resp_id  output  IDW  index of the requester that owns resp_p
resp_p  output  8  unsigned product a*b
busy  output  1  high whenever state is not IDLE
done_count  output  CNTW  number of completed response handshakes, wraps

Behaviour:
- Reset (async assert, sync release irrelevant): state=IDLE, rr_ptr=0, op_a=op_b=0, resp_p=0, resp_id=0, resp_valid=0, busy=0, done_count=0.
- Reset during MUL/RESP aborts the operation; no response is emitted for it.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - Grant g is the first index with req_valid set, searching g = rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 combinationally; all other bits are 0.
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
  - On the edge with a grant: op_a<=req_a[g], op_b<=req_b[g], id<=g, rr_ptr<=(g+1) mod NREQ, state<=MUL.
- MUL (1 cycle): the multiplier sees op_a/op_b. On the next edge resp_p<=product, resp_valid<=1, state<=RESP.
- RESP:
  - resp_valid=1, and resp_p/resp_id are held stable until resp_ready=1.
  - On the handshake edge: resp_valid<=0, done_count<=done_count+1 (wraps at 2^CNTW), state<=IDLE.
- req_ready=0 in MUL and RESP.
- req_ready depends only on state, rr_ptr and req_valid; there is no combinational path from resp_ready.
- Latency: accept at edge T, resp_valid high after edge T+1. Minimum 3 cycles per operation (IDLE, MUL, RESP). There is no back-to-back accept in RESP.
- Requester protocol:
  - Valid and operands are held until ready.
  - A requester that drops valid before acceptance simply loses its turn.
  - Arbitration is re-evaluated every IDLE cycle.
- Fairness: any continuously requesting requester is granted within NREQ grants.
- Arithmetic: unsigned 4x4 to 8-bit, full range 0..225, no truncation.
- Output registers: resp_p and resp_id are registers, not combinational multiplier outputs.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_MUL=2'd1, ST_RESP=2'd2
  - operand width 4
  - product width 8
- Sub-module rr_arbiter_n (parameter NREQ): inputs req, ptr, enable; outputs one-hot grant and grant index. Combinational only, reusable by later shared-resource controllers.
- The multiplier is instantiated unchanged as the existing carry-save array multiplier.

Test Plan:
- Single request: requester 0 sends a=3, b=5 → req_ready[0] the same cycle. resp_valid rises 2 edges after accept with resp_p=15, resp_id=0, resp_ready=1. done_count=1, busy low afterward.
- Boundary values, one at a time via requester 2:
  - a=15, b=15 gives 225.
  - a=0, b=9 gives 0.
  - a=8, b=2 gives 16.
- Arbitration: all 4 requesters valid continuously with distinct operands → grant order 0,1,2,3,0. Each resp_id matches its product. No requester waits more than 4 grants.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP with a=7, b=6 → resp_p=42 and resp_id stable, req_ready all 0. Release, and on the handshake the FSM returns to IDLE.
- Reset mid-operation: assert rst_n=0 while in MUL → outputs immediately reach reset values. After release, no stale response appears, done_count=0 and rr_ptr=0 (requester 0 is granted first).
- Counter wrap: with CNTW=8, complete 256 operations → done_count returns to 0.
